time_counter: RTL

Time-of-day counter for the digital clock: divides the system clock to a 1 Hz tick and keeps seconds, minutes and hours in binary. Each 7-bit field drives one binary-to-BCD converter directly; values never exceed 59 (sec/min) or 23 (hour), so a two-digit BCD result is always valid. A three-state mode machine lets the user set hours and minutes with two pre-debounced push-button pulses.

---
 rtl/time_counter.sv | 117 +++++++++++
 1 files changed

// File: rtl/time_counter.sv
// Time-of-day counter: 1 Hz prescaler, binary sec/min/hour fields and a RUN/SET_HOUR/SET_MIN mode machine.
// Optional 12-hour display (hour 1..12 plus pm flag) enabled by defining HOUR12_EN.
module time_counter #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [6:0] sec,
    output logic [6:0] min,
    output logic [6:0] hour,
    output logic       pm,
    output logic [1:0] mode,
    output logic       sec_tick
);

    localparam int PRE_W = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] pre_q;
    logic [6:0]       sec_q;
    logic [6:0]       min_q;
    logic [6:0]       hour_q;
    logic             tick_q;
    logic             tick;

    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] top);
        return (v == top) ? 7'd0 : v + 7'd1;
    endfunction

    // A mode press on the terminal count wins: the tick is dropped because sec is cleared anyway.
    assign tick = (state_q == RUN) && en && !mode_btn && (pre_q == PRE_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mode_btn) state_d = SET_HOUR;
            SET_HOUR: if (mode_btn) state_d = SET_MIN;
            SET_MIN:  if (mode_btn) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pre_q   <= '0;
            sec_q   <= 7'd0;
            min_q   <= 7'd0;
            hour_q  <= 7'd0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick;
            case (state_q)
                RUN: begin
                    if (mode_btn) begin
                        sec_q <= 7'd0;
                        pre_q <= '0;
                    end else if (en) begin
                        if (tick) begin
                            pre_q <= '0;
                            sec_q <= wrap_inc(sec_q, 7'd59);
                            if (sec_q == 7'd59) begin
                                min_q <= wrap_inc(min_q, 7'd59);
                                if (min_q == 7'd59) begin
                                    hour_q <= wrap_inc(hour_q, 7'd23);
                                end
                            end
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end
                end
                SET_HOUR: begin
                    if (!mode_btn && inc_btn) hour_q <= wrap_inc(hour_q, 7'd23);
                end
                SET_MIN: begin
                    if (!mode_btn && inc_btn) min_q <= wrap_inc(min_q, 7'd59);
                end
                default: ;
            endcase
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign mode     = state_q;
    assign sec_tick = tick_q;

`ifdef HOUR12_EN
    always_comb begin
        if (hour_q == 7'd0) begin
            hour = 7'd12;
        end else if (hour_q > 7'd12) begin
            hour = hour_q - 7'd12;
        end else begin
            hour = hour_q;
        end
        pm = (hour_q >= 7'd12);
    end
`else
    assign hour = hour_q;
    assign pm   = 1'b0;
`endif

endmodule
